// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
// Holds FSM state encoding, the decoded command type and the width defaults.
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;

  // Write dominates when both command bits are set.
  function automatic cmd_e decode_cmd(input logic mem_write, input logic mem_read);
    if (mem_write) begin
      return CMD_WRITE;
    end else if (mem_read) begin
      return CMD_READ;
    end
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, on contention the master
// that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;
  assign grant = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory slave port between m0 (CPU) and m1 (DMA/debug).
// One access in flight: IDLE arbitrates, ACCESS strobes the slave, RESP acks.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_WriteData,
  input  logic              m0_MemWrite,
  input  logic              m0_MemRead,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_ReadData,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_WriteData,
  input  logic              m1_MemWrite,
  input  logic              m1_MemRead,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_ReadData,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_WriteData,
  output logic              s_MemWrite,
  output logic              s_MemRead,
  input  logic [DATA_W-1:0] s_ReadData,
  output logic              owner,
  output logic              busy,
  output logic [CNT_W-1:0]  m0_count,
  output logic [CNT_W-1:0]  m1_count
);

  state_e            state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  cmd_e              cmd_q;
  logic [DATA_W-1:0] resp_q;

  logic              grant;
  logic              grant_valid;
  logic              in_access;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata [2];
  logic [CNT_W-1:0]  count [2];

  rr_arbiter2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .grant      (grant),
    .valid      (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      cmd_q        <= CMD_NONE;
      resp_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q      <= ST_ACCESS;
            owner_q      <= grant;
            last_grant_q <= grant;
            addr_q       <= grant ? m1_address : m0_address;
            wdata_q      <= grant ? m1_WriteData : m0_WriteData;
            cmd_q        <= grant ? decode_cmd(m1_MemWrite, m1_MemRead)
                                  : decode_cmd(m0_MemWrite, m0_MemRead);
          end
        end
        ST_ACCESS: begin
          // Writes and no-ops return zero to the master.
          resp_q  <= (cmd_q == CMD_READ) ? s_ReadData : '0;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_access   = (state_q == ST_ACCESS);
  assign s_address   = in_access ? addr_q  : '0;
  assign s_WriteData = in_access ? wdata_q : '0;
  assign s_MemWrite  = in_access && (cmd_q == CMD_WRITE);
  assign s_MemRead   = in_access && (cmd_q == CMD_READ);
  assign busy        = (state_q != ST_IDLE);
  assign owner       = busy && owner_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign ack[gi]   = (state_q == ST_RESP) && (owner_q == 1'(gi));
    assign rdata[gi] = ack[gi] ? resp_q : '0;
    assign count[gi] = cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (ack[gi] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign m0_ack      = ack[0];
  assign m1_ack      = ack[1];
  assign m0_ReadData = rdata[0];
  assign m1_ReadData = rdata[1];
  assign m0_count    = count[0];
  assign m1_count    = count[1];

endmodule
